// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory stalls, branch flushes and load-use stalls
// for a five-stage pipeline, with saturating stall/flush event counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// HOLD     | after reset: freeze every stage register and bubble all stages
// RUN      | normal issue; branch flush and load-use stall are evaluated
// MEM_WAIT | waiting on data memory; the cycle it completes releases all stages
module pipe_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  ID_EX_rd,
  input  logic [4:0]  IF_ID_rs1,
  input  logic [4:0]  IF_ID_rs2,
  input  logic [1:0]  ID_EX_WDSel,
  input  logic        EX_MEM_mem_req,
  input  logic        EX_MEM_br_taken,
  input  logic        dmem_ready,
  output logic        PC_we,
  output logic        IF_ID_we,
  output logic        ID_EX_we,
  output logic        EX_MEM_we,
  output logic        MEM_WB_we,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        EX_MEM_flush,
  output logic        MEM_WB_flush,
  output logic        dmem_req,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   lu_hit;
  logic   mem_stall, br_flush, lu_stall;

  // A load writing x0 never creates a real dependency.
  always_comb begin
    lu_hit = (ID_EX_WDSel == 2'b01) && (ID_EX_rd != 5'd0) &&
             ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
  end

  always_comb begin
    state_nxt    = state;
    PC_we        = 1'b1;
    IF_ID_we     = 1'b1;
    ID_EX_we     = 1'b1;
    EX_MEM_we    = 1'b1;
    MEM_WB_we    = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    MEM_WB_flush = 1'b0;
    dmem_req     = 1'b0;
    mem_stall    = 1'b0;
    br_flush     = 1'b0;
    lu_stall     = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        dmem_req = EX_MEM_mem_req;
        if (EX_MEM_mem_req && !dmem_ready) begin
          // Freeze everything up to MEM; MEM_WB takes a bubble meanwhile.
          mem_stall    = 1'b1;
          PC_we        = 1'b0;
          IF_ID_we     = 1'b0;
          ID_EX_we     = 1'b0;
          EX_MEM_we    = 1'b0;
          MEM_WB_flush = 1'b1;
          state_nxt    = MEM_WAIT;
        end else if (state == MEM_WAIT) begin
          state_nxt = RUN;
        end else if (EX_MEM_br_taken) begin
          br_flush     = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          EX_MEM_flush = 1'b1;
        end else if (lu_hit) begin
          lu_stall    = 1'b1;
          PC_we       = 1'b0;
          IF_ID_we    = 1'b0;
          ID_EX_flush = 1'b1;
        end
      end
      default: begin
        PC_we        = 1'b0;
        IF_ID_we     = 1'b0;
        ID_EX_we     = 1'b0;
        EX_MEM_we    = 1'b0;
        MEM_WB_we    = 1'b0;
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        EX_MEM_flush = 1'b1;
        MEM_WB_flush = 1'b1;
        state_nxt    = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= HOLD;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if ((mem_stall || lu_stall) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (br_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-scenario tasks push expected control
// vectors to a scoreboard queue and compare them against the DUT each cycle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  ID_EX_rd, IF_ID_rs1, IF_ID_rs2;
  logic [1:0]  ID_EX_WDSel;
  logic        EX_MEM_mem_req, EX_MEM_br_taken, dmem_ready;
  logic        PC_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we;
  logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
  logic        dmem_req;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_ctrl dut (
    .clk(clk), .rstn(rstn),
    .ID_EX_rd(ID_EX_rd), .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .ID_EX_WDSel(ID_EX_WDSel), .EX_MEM_mem_req(EX_MEM_mem_req),
    .EX_MEM_br_taken(EX_MEM_br_taken), .dmem_ready(dmem_ready),
    .PC_we(PC_we), .IF_ID_we(IF_ID_we), .ID_EX_we(ID_EX_we),
    .EX_MEM_we(EX_MEM_we), .MEM_WB_we(MEM_WB_we),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
    .dmem_req(dmem_req), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {PC_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we,
  //  IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, dmem_req}
  logic [9:0] ctl;
  assign ctl = {PC_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we,
                IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush, dmem_req};

  localparam logic [9:0] C_HOLD  = 10'b00000_1111_0;
  localparam logic [9:0] C_NORM0 = 10'b11111_0000_0;
  localparam logic [9:0] C_NORM1 = 10'b11111_0000_1;
  localparam logic [9:0] C_MEMST = 10'b00001_0001_1;
  localparam logic [9:0] C_BR    = 10'b11111_1110_0;
  localparam logic [9:0] C_LU    = 10'b00111_0100_0;

  typedef struct packed {
    logic [4:0] rd, rs1, rs2;
    logic [1:0] wd;
    logic       mreq, br, rdy;
    logic [9:0] ctl;
  } step_t;

  logic [9:0]  sb [$];
  logic [9:0]  exp_c;
  logic [15:0] exp_stall, exp_flush;
  int          checks = 0;
  int          errors = 0;

  function automatic step_t mk(input logic [4:0] rd, rs1, rs2, input logic [1:0] wd,
                               input logic mreq, br, rdy, input logic [9:0] c);
    step_t s;
    s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.wd = wd;
    s.mreq = mreq; s.br = br; s.rdy = rdy; s.ctl = c;
    return s;
  endfunction

  task automatic drive(input step_t s);
    ID_EX_rd        = s.rd;
    IF_ID_rs1       = s.rs1;
    IF_ID_rs2       = s.rs2;
    ID_EX_WDSel     = s.wd;
    EX_MEM_mem_req  = s.mreq;
    EX_MEM_br_taken = s.br;
    dmem_ready      = s.rdy;
  endtask

  task automatic test_reset();
    checks++;
    if (ctl !== C_HOLD) begin errors++; $display("FAIL reset_in ctl got %b want %b", ctl, C_HOLD); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    rstn = 1'b1;
    sb.push_back(C_HOLD);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL reset_cycle0 ctl got %b want %b", ctl, exp_c); end
    @(negedge clk);
    sb.push_back(C_NORM0);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL reset_cycle1 ctl got %b want %b", ctl, exp_c); end
    @(negedge clk);
    exp_stall = 16'd0;
    exp_flush = 16'd0;
  endtask

  task automatic test_load_use();
    step_t s [$];
    s.push_back(mk(5'd5, 5'd3, 5'd5, 2'b01, 0, 0, 0, C_LU));
    s.push_back(mk(5'd0, 5'd5, 5'd5, 2'b00, 0, 0, 0, C_NORM0));
    s.push_back(mk(5'd7, 5'd7, 5'd2, 2'b01, 0, 0, 0, C_LU));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NORM0));
    s.push_back(mk(5'd9, 5'd9, 5'd9, 2'b00, 0, 0, 0, C_NORM0));
    s.push_back(mk(5'd9, 5'd9, 5'd9, 2'b10, 0, 0, 0, C_NORM0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].ctl);
      #1; exp_c = sb.pop_front(); checks++;
      if (ctl !== exp_c) begin errors++; $display("FAIL load_use step %0d ctl got %b want %b", i, ctl, exp_c); end
      @(negedge clk);
    end
    exp_stall += 16'd2;
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL load_use stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_x0();
    step_t s [$];
    s.push_back(mk(5'd0, 5'd0, 5'd4, 2'b01, 0, 0, 0, C_NORM0));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0, C_NORM0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].ctl);
      #1; exp_c = sb.pop_front(); checks++;
      if (ctl !== exp_c) begin errors++; $display("FAIL x0 step %0d ctl got %b want %b", i, ctl, exp_c); end
      @(negedge clk);
    end
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL x0 stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_mem_wait();
    step_t s [$];
    s.push_back(mk(0, 0, 0, 2'b00, 1, 0, 1, C_NORM1));
    s.push_back(mk(0, 0, 0, 2'b00, 1, 0, 0, C_MEMST));
    s.push_back(mk(0, 0, 0, 2'b00, 1, 0, 0, C_MEMST));
    s.push_back(mk(0, 0, 0, 2'b00, 1, 0, 0, C_MEMST));
    s.push_back(mk(0, 0, 0, 2'b00, 1, 0, 1, C_NORM1));
    s.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, C_NORM0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].ctl);
      #1; exp_c = sb.pop_front(); checks++;
      if (ctl !== exp_c) begin errors++; $display("FAIL mem_wait step %0d ctl got %b want %b", i, ctl, exp_c); end
      @(negedge clk);
    end
    exp_stall += 16'd3;
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL mem_wait stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_priority();
    step_t s [$];
    s.push_back(mk(5'd5, 5'd5, 5'd0, 2'b01, 1, 1, 0, C_MEMST));
    s.push_back(mk(5'd5, 5'd5, 5'd0, 2'b01, 1, 1, 0, C_MEMST));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 1, C_NORM1));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NORM0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].ctl);
      #1; exp_c = sb.pop_front(); checks++;
      if (ctl !== exp_c) begin errors++; $display("FAIL priority step %0d ctl got %b want %b", i, ctl, exp_c); end
      @(negedge clk);
    end
    exp_stall += 16'd2;
    checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      errors++; $display("FAIL priority cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_branch();
    step_t s [$];
    s.push_back(mk(5'd5, 5'd5, 5'd0, 2'b01, 0, 1, 0, C_BR));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 0, C_BR));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NORM0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].ctl);
      #1; exp_c = sb.pop_front(); checks++;
      if (ctl !== exp_c) begin errors++; $display("FAIL branch step %0d ctl got %b want %b", i, ctl, exp_c); end
      @(negedge clk);
    end
    exp_flush += 16'd2;
    checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      errors++; $display("FAIL branch cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_back_to_back();
    step_t s [$];
    s.push_back(mk(5'd3, 5'd3, 5'd0, 2'b01, 0, 0, 0, C_LU));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 0, C_BR));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 0, C_MEMST));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 1, C_NORM1));
    s.push_back(mk(5'd4, 5'd0, 5'd4, 2'b01, 0, 0, 0, C_LU));
    s.push_back(mk(5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NORM0));
    foreach (s[i]) begin
      drive(s[i]); sb.push_back(s[i].ctl);
      #1; exp_c = sb.pop_front(); checks++;
      if (ctl !== exp_c) begin errors++; $display("FAIL back_to_back step %0d ctl got %b want %b", i, ctl, exp_c); end
      @(negedge clk);
    end
    exp_stall += 16'd3;
    exp_flush += 16'd1;
    checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      errors++; $display("FAIL back_to_back cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mem_wait();
    step_t st;
    st = mk(5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 0, C_MEMST);
    drive(st);
    repeat (2) @(negedge clk);
    exp_stall += 16'd2;
    rstn = 1'b0;
    sb.push_back(C_MEMST);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL rst_mw before_edge ctl got %b want %b", ctl, exp_c); end
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL rst_mw before_edge stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
    @(negedge clk);
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    sb.push_back(C_HOLD);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL rst_mw hold ctl got %b want %b", ctl, exp_c); end
    checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
      errors++; $display("FAIL rst_mw cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive(mk(0, 0, 0, 2'b00, 0, 0, 0, C_NORM0));
    sb.push_back(C_HOLD);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL rst_mw release0 ctl got %b want %b", ctl, exp_c); end
    @(negedge clk);
    sb.push_back(C_NORM0);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL rst_mw release1 ctl got %b want %b", ctl, exp_c); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    drive(mk(5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 0, C_MEMST));
    sb.push_back(C_MEMST);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL saturate ctl got %b want %b", ctl, exp_c); end
    repeat (65535) @(negedge clk);
    exp_stall = 16'hFFFF;
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL saturate reach got %h want %h", stall_cnt, exp_stall); end
    @(negedge clk);
    checks++;
    if (stall_cnt !== exp_stall) begin errors++; $display("FAIL saturate hold got %h want %h", stall_cnt, exp_stall); end
    drive(mk(5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 1, C_NORM1));
    sb.push_back(C_NORM1);
    #1; exp_c = sb.pop_front(); checks++;
    if (ctl !== exp_c) begin errors++; $display("FAIL saturate release ctl got %b want %b", ctl, exp_c); end
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    drive(mk(0, 0, 0, 2'b00, 0, 0, 0, C_NORM0));
    exp_stall = 16'd0;
    exp_flush = 16'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_load_use();
    test_x0();
    test_mem_wait();
    test_priority();
    test_branch();
    test_back_to_back();
    test_reset_mem_wait();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports named clk and rstn.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  synchronous active-low reset.
REQ-004 ID_EX_rd  input  5  destination register of the instruction in EX.
REQ-005 IF_ID_rs1 / IF_ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 ID_EX_WDSel  input  2  write-back select of the EX instruction; 2'b01 means load.
REQ-007 EX_MEM_mem_req  input  1  the instruction in MEM is a load or store.
REQ-008 EX_MEM_br_taken  input  1  a branch or jump resolved taken in MEM.
REQ-009 dmem_ready  input  1  data memory completes the access this cycle; driven combinationally by the memory.
REQ-010 PC_we, IF_ID_we, ID_EX_we, EX_MEM_we, MEM_WB_we  output  1 each  stage-register write enables.
REQ-011 IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  output  1 each  insert a bubble at the next edge.
REQ-012 dmem_req  output  1  data-memory access request.
REQ-013 stall_cnt, flush_cnt  output  16 each  saturating event counters.

Function
REQ-014 The FSM SHALL have three states: HOLD, RUN and MEM_WAIT, held in a registered state variable.
REQ-015 Control outputs SHALL be combinational from the state and the current inputs; the state and counters SHALL be registered.
REQ-016 HOLD SHALL drive all *_we=0, all *_flush=1 and dmem_req=0, and SHALL move to RUN on the next edge.
REQ-017 dmem_req SHALL equal EX_MEM_mem_req in RUN and MEM_WAIT, and SHALL be 0 in HOLD.
REQ-018 A memory stall is active when the state is RUN or MEM_WAIT, EX_MEM_mem_req=1 and dmem_ready=0.
REQ-019 During a memory stall, the block SHALL drive PC_we, IF_ID_we, ID_EX_we and EX_MEM_we to 0, MEM_WB_flush to 1, and every other flush to 0.
REQ-020 During a memory stall, the next state SHALL be MEM_WAIT.
REQ-021 In MEM_WAIT with dmem_ready=1, all stages SHALL advance (all *_we=1, no flush) and the next state SHALL be RUN.
REQ-022 A memory stall SHALL have priority over the branch flush and the load-use stall.
REQ-023 If EX_MEM_br_taken and EX_MEM_mem_req are both 1, the block SHALL treat it as a memory stall only.
REQ-024 Branch flush applies in RUN when EX_MEM_br_taken=1 and there is no memory stall.
REQ-025 During a branch flush, the block SHALL drive all *_we=1, IF_ID_flush=ID_EX_flush=EX_MEM_flush=1 and MEM_WB_flush=0, so the PC loads the target.
REQ-026 Branch flush SHALL override the load-use stall.
REQ-027 Load-use stall applies in RUN with no memory stall and no branch when ID_EX_WDSel=2'b01, ID_EX_rd!=0 and ID_EX_rd equals IF_ID_rs1 or IF_ID_rs2.
REQ-028 During a load-use stall, the block SHALL drive PC_we=IF_ID_we=0, ID_EX_flush=1 and the other we=1, for exactly one cycle per occurrence.
REQ-029 When no stall or flush condition applies, the block SHALL drive all *_we=1 and all flushes=0.
REQ-030 stall_cnt SHALL increment once per cycle of memory stall or load-use stall and SHALL saturate at 16'hFFFF.
REQ-031 flush_cnt SHALL increment once per branch-flush cycle and SHALL saturate at 16'hFFFF.
REQ-032 Latency: the decision SHALL be visible in the same cycle as its inputs, and the affected registers SHALL update at the next edge.

Reset
REQ-033 While rstn=0 at an edge, the block SHALL set the state to HOLD and stall_cnt=flush_cnt=0, overriding any in-progress MEM_WAIT.
REQ-034 After rstn rises, the block SHALL spend exactly one cycle in HOLD before entering RUN.
REQ-035 Reset SHALL take effect only at a clock edge.

Verification
REQ-036 Release rstn -> cycle 0: HOLD outputs (all we=0, all flush=1); cycle 1: RUN with all we=1.
REQ-037 Load-use: ID_EX_rd=5, WDSel=01, IF_ID_rs2=5 -> one cycle PC_we=IF_ID_we=0, ID_EX_flush=1; stall_cnt +1.
REQ-038 Load-use to x0 (ID_EX_rd=0, rs1=0): no stall.
REQ-039 mem_req=1 with dmem_ready low for 3 cycles, then high: 3 stall cycles in MEM_WAIT, release cycle all we=1, then RUN; stall_cnt +3.
REQ-040 br_taken=1 with a simultaneous load-use hit -> IF_ID/ID_EX/EX_MEM flush=1, PC_we=1; flush_cnt +1; stall_cnt unchanged.
REQ-041 rstn=0 during MEM_WAIT -> HOLD at the next edge, counters 0; stall_cnt preset to 16'hFFFF plus one more stall stays at 16'hFFFF.
